// File: rtl/rt_pkg.sv
// ---------------------------------------------------------------------------
// rt_pkg -- shared definitions for the reaction timer.
//   REACT_W    : width of the reaction-time result (ms)
//   REACT_SAT  : saturation value of the reaction counter
//   rt_state_e : FSM state encoding
//   delay_width: bits needed to hold BASE_DELAY_MS + the largest random delay
// Optional feature macro: RT_FALSE_START_EN adds the FALSE_START state.
// ---------------------------------------------------------------------------
package rt_pkg;

    localparam int                 REACT_W   = 16;
    localparam logic [REACT_W-1:0] REACT_SAT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT        = 3'd1,
        ST_GO          = 3'd2,
`ifdef RT_FALSE_START_EN
        ST_DONE        = 3'd3,
        ST_FALSE_START = 3'd4
`else
        ST_DONE        = 3'd3
`endif
    } rt_state_e;

    // Largest latched delay is base + 2^rbits - 1, so clog2(base + 2^rbits)
    // bits hold it exactly.
    function automatic int delay_width(input int base, input int rbits);
        int w;
        w = $clog2(base + (1 << rbits));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen -- millisecond prescaler.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   clear  : synchronous restart of the count (takes priority over enable)
//   enable : count while high, hold while low
//   tick   : one-cycle strobe in the cycle the count wraps at CLKS_PER_MS-1
// Parameter CLKS_PER_MS : clock cycles per tick.
// ---------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             CNT_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_MS - 1);

    logic [CNT_W-1:0] cnt;

    // A cycle with clear asserted is not a counting cycle, so no tick there.
    assign tick = enable && !clear && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// ---------------------------------------------------------------------------
// reaction_timer -- human reaction-time trial controller.
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high, highest priority
//   random_value : free-running random number; low RAND_BITS bits add delay
//   start        : begin a trial (sampled only in IDLE)
//   button       : debounced player button, active-high
//   led_on       : go-stimulus, high only in GO
//   busy         : high in every state except IDLE
//   reaction_ms  : last measured reaction time in ms
//   result_valid : one-cycle pulse when reaction_ms/timeout/early update
//   timeout      : last trial ended by counter saturation
//   early        : last trial ended by a false start
// Parameters: CLKS_PER_MS, BASE_DELAY_MS, RAND_BITS (1..18).
// Optional feature macro: RT_FALSE_START_EN -- button during WAIT ends the
// trial through FALSE_START; without it the button is ignored in WAIT and
// early is tied low.
// ---------------------------------------------------------------------------
module reaction_timer
    import rt_pkg::*;
#(
    parameter int CLKS_PER_MS   = 50000,
    parameter int BASE_DELAY_MS = 1000,
    parameter int RAND_BITS     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [17:0]        random_value,
    input  logic               start,
    input  logic               button,
    output logic               led_on,
    output logic               busy,
    output logic [REACT_W-1:0] reaction_ms,
    output logic               result_valid,
    output logic               timeout,
    output logic               early
);

    localparam int DLY_W = delay_width(BASE_DELAY_MS, RAND_BITS);

    rt_state_e          state;
    logic [DLY_W-1:0]   delay_ms;
    logic [REACT_W-1:0] react_cnt;
    logic               entry;      // high in the first cycle of every state
    logic               ms_tick;
    logic               tick_en;
    logic               unused_rand;

    // Only the low RAND_BITS of random_value feed the delay.
    assign unused_rand = ^random_value;

    assign tick_en = (state == ST_WAIT) || (state == ST_GO);

    // The prescaler is cleared in the first cycle of each state, so the first
    // ms_tick of a state arrives CLKS_PER_MS+1 edges after the entry edge.
    // That extra cycle is what places the GO entry at delay*CLKS_PER_MS+1.
    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_ms_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (entry),
        .enable (tick_en),
        .tick   (ms_tick)
    );

`ifdef RT_FALSE_START_EN
    logic early_r;
    assign early = early_r;
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            entry        <= 1'b0;
            delay_ms     <= '0;
            react_cnt    <= '0;
            led_on       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            reaction_ms  <= '0;
            timeout      <= 1'b0;
`ifdef RT_FALSE_START_EN
            early_r      <= 1'b0;
`endif
        end else begin
            entry        <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start wins over a simultaneous button press here
                    if (start) begin
                        delay_ms <= DLY_W'(BASE_DELAY_MS)
                                  + DLY_W'(random_value[RAND_BITS-1:0]);
                        state    <= ST_WAIT;
                        busy     <= 1'b1;
                        entry    <= 1'b1;
                    end
                end

                ST_WAIT: begin
`ifdef RT_FALSE_START_EN
                    if (button) begin
                        state        <= ST_FALSE_START;
                        entry        <= 1'b1;
                        result_valid <= 1'b1;
                        reaction_ms  <= '0;
                        timeout      <= 1'b0;
                        early_r      <= 1'b1;
                    end else
`endif
                    // delay_ms only sits at zero when it was latched as zero
                    if ((delay_ms == '0) || (ms_tick && (delay_ms == DLY_W'(1)))) begin
                        delay_ms  <= '0;
                        react_cnt <= '0;
                        state     <= ST_GO;
                        led_on    <= 1'b1;
                        entry     <= 1'b1;
                    end else if (ms_tick) begin
                        delay_ms <= delay_ms - DLY_W'(1);
                    end
                end

                ST_GO: begin
                    if (button) begin
                        state        <= ST_DONE;
                        led_on       <= 1'b0;
                        entry        <= 1'b1;
                        result_valid <= 1'b1;
                        reaction_ms  <= react_cnt;
                        timeout      <= 1'b0;
`ifdef RT_FALSE_START_EN
                        early_r      <= 1'b0;
`endif
                    end else if (react_cnt == REACT_SAT) begin
                        // saturate instead of wrapping
                        state        <= ST_DONE;
                        led_on       <= 1'b0;
                        entry        <= 1'b1;
                        result_valid <= 1'b1;
                        reaction_ms  <= REACT_SAT;
                        timeout      <= 1'b1;
`ifdef RT_FALSE_START_EN
                        early_r      <= 1'b0;
`endif
                    end else if (ms_tick) begin
                        react_cnt <= react_cnt + REACT_W'(1);
                    end
                end

`ifdef RT_FALSE_START_EN
                ST_DONE, ST_FALSE_START: begin
`else
                ST_DONE: begin
`endif
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    entry <= 1'b1;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    led_on <= 1'b0;
                    entry  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer -- self-checking bench for reaction_timer.
// Main instance: CLKS_PER_MS=4, BASE_DELAY_MS=2, RAND_BITS=2.
// Second instance with CLKS_PER_MS=1 runs the saturation trial in parallel
// so the 65535-tick timeout stays short in cycles.
// Honours RT_FALSE_START_EN when defined.
// ---------------------------------------------------------------------------
module tb_reaction_timer;

    localparam int CPM  = 4;
    localparam int BASE = 2;
    localparam int RB   = 2;

    logic        clk = 1'b0;
    logic        reset, start, button;
    logic [17:0] random_value;
    logic        led_on, busy, result_valid, timeout, early;
    logic [15:0] reaction_ms;

    logic        s_reset, s_start, s_button;
    logic [17:0] s_rv;
    logic        s_led, s_busy, s_vld, s_timeout, s_early;
    logic [15:0] s_rms;
    logic        sat_done = 1'b0;

    always #5 clk = ~clk;

    reaction_timer #(
        .CLKS_PER_MS (CPM), .BASE_DELAY_MS (BASE), .RAND_BITS (RB)
    ) u_dut (
        .clk (clk), .reset (reset), .random_value (random_value),
        .start (start), .button (button), .led_on (led_on), .busy (busy),
        .reaction_ms (reaction_ms), .result_valid (result_valid),
        .timeout (timeout), .early (early)
    );

    reaction_timer #(
        .CLKS_PER_MS (1), .BASE_DELAY_MS (BASE), .RAND_BITS (RB)
    ) u_sat (
        .clk (clk), .reset (s_reset), .random_value (s_rv),
        .start (s_start), .button (s_button), .led_on (s_led), .busy (s_busy),
        .reaction_ms (s_rms), .result_valid (s_vld),
        .timeout (s_timeout), .early (s_early)
    );

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference timing, straight from the rules: the trial waits
    // (BASE + low bits) ms, the stimulus appears one cycle after that many
    // prescaler periods, and a button first seen n edges into GO has
    // witnessed floor((n-2)/CPM) completed milliseconds.
    function automatic int ref_led(input logic [17:0] rv);
        int r;
        r = int'(rv);
        return (BASE + (r % (1 << RB))) * CPM + 1;
    endfunction

    function automatic int ref_react(input int n);
        return (n < 2) ? 0 : (n - 2) / CPM;
    endfunction

    // Tick until led_on rises; idx counts edges since the start edge.
    task automatic wait_led(input int exp_idx, input int already, input bit restart);
        int idx;
        bit seen;
        idx  = already;
        seen = 1'b0;
        while (!seen && idx < 5000) begin
            start = restart ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            idx++;
            if (led_on) seen = 1'b1;
        end
        start = 1'b0;
        check("led_rise_cycle", 32'(idx), 32'(exp_idx));
    endtask

    // From the GO entry edge, make the button first sampled at edge n.
    task automatic press(input int n, input bit restart, input int exp);
        int stray;
        stray  = 0;
        button = 1'b0;
        for (int i = 1; i < n; i++) begin
            start = restart ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (result_valid) stray++;
        end
        button = 1'b1;
        start  = restart;
        tick();
        button = 1'b0;
        check("stray_result", 32'(stray), 32'd0);
        check("done_valid",   32'(result_valid), 32'd1);
        check("done_react",   32'(reaction_ms), 32'(exp));
        check("done_timeout", 32'(timeout), 32'd0);
        check("done_early",   32'(early), 32'd0);
        check("done_led",     32'(led_on), 32'd0);
        check("done_busy",    32'(busy), 32'd1);
        start = restart;       // start during DONE must be ignored
        tick();
        start = 1'b0;
        check("idle_valid", 32'(result_valid), 32'd0);
        check("idle_busy",  32'(busy), 32'd0);
        check("hold_react", 32'(reaction_ms), 32'(exp));
    endtask

    task automatic do_trial(input logic [17:0] rv, input int n, input bit restart);
        random_value = rv;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        random_value = 18'($urandom);
        wait_led(ref_led(rv), 0, restart);
        press(n, restart, ref_react(n));
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        btn;
        logic [17:0] rv;
        logic        e_led;
        logic        e_busy;
        logic        e_vld;
        logic [15:0] e_rms;
    } vec_t;

    vec_t tbl[9];

    // ---------------- main instance ----------------
    initial begin
        reset = 1'b1; start = 1'b0; button = 1'b0; random_value = '0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 16'h0}; // reset
        tbl[1] = '{1'b1, 1'b1, 1'b1, 18'h3, 1'b0, 1'b0, 1'b0, 16'h0}; // reset beats inputs
        tbl[2] = '{1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 16'h0}; // idle
        tbl[3] = '{1'b0, 1'b1, 1'b0, 18'h3, 1'b0, 1'b1, 1'b0, 16'h0}; // start -> WAIT
        tbl[4] = '{1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0, 16'h0}; // waiting
        tbl[5] = '{1'b1, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 16'h0}; // reset in WAIT
        tbl[6] = '{1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 16'h0}; // idle again
        tbl[7] = '{1'b0, 1'b1, 1'b1, 18'h1, 1'b0, 1'b1, 1'b0, 16'h0}; // start+button in IDLE
        tbl[8] = '{1'b0, 1'b1, 1'b0, 18'h2, 1'b0, 1'b1, 1'b0, 16'h0}; // start in WAIT ignored

        for (int i = 0; i < 9; i++) begin
            reset        = tbl[i].rst;
            start        = tbl[i].st;
            button       = tbl[i].btn;
            random_value = tbl[i].rv;
            tick();
            check($sformatf("tbl%0d_led", i),  32'(led_on),       32'(tbl[i].e_led));
            check($sformatf("tbl%0d_busy", i), 32'(busy),         32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_vld", i),  32'(result_valid), 32'(tbl[i].e_vld));
            check($sformatf("tbl%0d_rms", i),  32'(reaction_ms),  32'(tbl[i].e_rms));
            check($sformatf("tbl%0d_to", i),   32'(timeout),      32'd0);
            check($sformatf("tbl%0d_early", i), 32'(early),       32'd0);
        end
        reset = 1'b0; start = 1'b0; button = 1'b0;

        // Trial started by vector 7 (delay 3 ms); button in first GO cycle.
        wait_led(13, 1, 1'b0);
        press(1, 1'b0, 0);

        // Reference trial: delay 5 ms, led at 21, button 3 ms + 1 cycle later.
        random_value = 18'h3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_led(21, 0, 1'b0);
        press(14, 1'b0, 3);

        // Reset during GO clears everything.
        random_value = 18'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_led(ref_led(18'h0), 0, 1'b0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstgo_led",   32'(led_on), 32'd0);
        check("rstgo_busy",  32'(busy), 32'd0);
        check("rstgo_vld",   32'(result_valid), 32'd0);
        check("rstgo_rms",   32'(reaction_ms), 32'd0);
        check("rstgo_to",    32'(timeout), 32'd0);
        check("rstgo_early", 32'(early), 32'd0);
        tick();
        check("rstgo_idle", 32'(busy), 32'd0);
        do_trial(18'h3, 14, 1'b0);

        // Button during WAIT.
        random_value = 18'h2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        button = 1'b1;
        tick();
        button = 1'b0;
`ifdef RT_FALSE_START_EN
        check("fs_valid", 32'(result_valid), 32'd1);
        check("fs_early", 32'(early), 32'd1);
        check("fs_to",    32'(timeout), 32'd0);
        check("fs_rms",   32'(reaction_ms), 32'd0);
        check("fs_led",   32'(led_on), 32'd0);
        tick();
        check("fs_after_vld",  32'(result_valid), 32'd0);
        check("fs_after_busy", 32'(busy), 32'd0);
        check("fs_hold_early", 32'(early), 32'd1);
        do_trial(18'h1, 5, 1'b0);
`else
        check("wait_btn_vld",   32'(result_valid), 32'd0);
        check("wait_btn_early", 32'(early), 32'd0);
        check("wait_btn_busy",  32'(busy), 32'd1);
        wait_led(ref_led(18'h2), 3, 1'b0);
        press(6, 1'b0, ref_react(6));
`endif

        // Randomized trials, some with start re-pulsed while busy.
        for (int k = 0; k < 25; k++) begin
            do_trial(18'($urandom), $urandom_range(1, 24), 1'($urandom_range(0, 1)));
        end

        begin
            int w;
            w = 0;
            while (!sat_done && w < 100000) begin
                tick();
                w++;
            end
            check("sat_finished", 32'(sat_done), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // ---------------- saturation instance (1 clock per ms) ----------------
    initial begin
        int idx;
        s_reset = 1'b1; s_start = 1'b0; s_button = 1'b0; s_rv = 18'h0;
        tick();
        tick();
        s_reset = 1'b0;
        tick();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        idx = 0;
        while (!s_led && idx < 100) begin
            tick();
            idx++;
        end
        check("sat_led_cycle", 32'(idx), 32'd3);
        idx = 0;
        while (!s_vld && idx < 70000) begin
            tick();
            idx++;
        end
        check("sat_latency", 32'(idx), 32'd65537);
        check("sat_rms",     32'(s_rms), 32'hFFFF);
        check("sat_timeout", 32'(s_timeout), 32'd1);
        check("sat_early",   32'(s_early), 32'd0);
        tick();
        check("sat_vld_pulse", 32'(s_vld), 32'd0);
        check("sat_busy",      32'(s_busy), 32'd0);
        check("sat_hold_to",   32'(s_timeout), 32'd1);

        // Following trial clears timeout: button first seen at GO edge 3.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        idx = 0;
        while (!s_led && idx < 100) begin
            tick();
            idx++;
        end
        tick();
        tick();
        s_button = 1'b1;
        tick();
        s_button = 1'b0;
        check("sat2_vld", 32'(s_vld), 32'd1);
        check("sat2_rms", 32'(s_rms), 32'd1);
        check("sat2_to",  32'(s_timeout), 32'd0);
        sat_done = 1'b1;
    end

endmodule
